// File: rtl/wishbone_ram_mux_param_if.sv
// Wishbone signal bundle for wishbone_ram_mux_param: one upstream master port
// and N_PORTS downstream SRAM/ROM ports, packed as flat vectors.
interface wishbone_ram_mux_param_if #(
  parameter int N_PORTS = 11
);
  logic                    wbs_ufp_stb_i;
  logic                    wbs_ufp_cyc_i;
  logic                    wbs_ufp_we_i;
  logic [3:0]              wbs_ufp_sel_i;
  logic [31:0]             wbs_ufp_adr_i;
  logic [31:0]             wbs_ufp_dat_i;
  logic                    wbs_ufp_ack_o;
  logic [31:0]             wbs_ufp_dat_o;
  logic [N_PORTS-1:0]      wbs_dfp_stb_o;
  logic [N_PORTS-1:0]      wbs_dfp_cyc_o;
  logic [N_PORTS-1:0]      wbs_dfp_we_o;
  logic [4*N_PORTS-1:0]    wbs_dfp_sel_o;
  logic [32*N_PORTS-1:0]   wbs_dfp_dat_o;
  logic [32*N_PORTS-1:0]   wbs_dfp_dat_i;
  logic [N_PORTS-1:0]      wbs_dfp_ack_i;

  modport slave (
    input  wbs_ufp_stb_i, wbs_ufp_cyc_i, wbs_ufp_we_i, wbs_ufp_sel_i,
    input  wbs_ufp_adr_i, wbs_ufp_dat_i,
    output wbs_ufp_ack_o, wbs_ufp_dat_o,
    output wbs_dfp_stb_o, wbs_dfp_cyc_o, wbs_dfp_we_o, wbs_dfp_sel_o, wbs_dfp_dat_o,
    input  wbs_dfp_dat_i, wbs_dfp_ack_i
  );

  modport master (
    output wbs_ufp_stb_i, wbs_ufp_cyc_i, wbs_ufp_we_i, wbs_ufp_sel_i,
    output wbs_ufp_adr_i, wbs_ufp_dat_i,
    input  wbs_ufp_ack_o, wbs_ufp_dat_o,
    input  wbs_dfp_stb_o, wbs_dfp_cyc_o, wbs_dfp_we_o, wbs_dfp_sel_o, wbs_dfp_dat_o,
    output wbs_dfp_dat_i, wbs_dfp_ack_i
  );
endinterface

// File: rtl/wishbone_ram_mux_param.sv
// Wishbone classic 1-to-N SRAM/ROM router with registered response path and
// local error termination (unmapped, read-only write, downstream hang).
module wishbone_ram_mux_param #(
  parameter int          N_PORTS     = 11,
  parameter logic [11:0] BASE_PREFIX = 12'h300,
  parameter logic [63:0] PORT_AW     = {16{4'd12}},
  parameter logic [15:0] RO_MASK     = 16'h0400,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] DEAD_DATA   = 32'hDEAD_BEEF
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  wishbone_ram_mux_param_if.slave  bus,
  output logic [7:0]               err_count_o,
  output logic [31:0]              last_err_adr_o
);

  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_WAIT = 2'd1;
  localparam logic [1:0]  ST_RESP = 2'd2;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [N_PORTS-1:0]    port_sel;
  logic [31:0]           adr_lat;
  logic [15:0]           wait_cnt;
  logic                  ack_reg;
  logic [31:0]           dat_reg;
  logic [7:0]            err_cnt;
  logic [31:0]           err_adr;
  logic [N_PORTS-1:0]    dfp_stb;
  logic [N_PORTS-1:0]    dfp_cyc;
  logic [N_PORTS-1:0]    dfp_we;
  logic [4*N_PORTS-1:0]  dfp_sel;
  logic [32*N_PORTS-1:0] dfp_dat;

  logic                  req_s;
  logic                  hit_s;
  logic                  reject_s;
  logic [N_PORTS-1:0]    req_oh_s;
  logic                  slv_ack_s;
  logic [31:0]           slv_dat_s;
  logic                  resp_err_s;

  // Window check: prefix match, existing port, offset inside the 2^AW byte window.
  function automatic logic win_hit(input logic [31:0] adr);
    logic [3:0] aw;
    aw = PORT_AW[{adr[19:16], 2'b00} +: 4];
    return (adr[31:20] == BASE_PREFIX) &&
           ({28'd0, adr[19:16]} < 32'(N_PORTS)) &&
           ((adr[15:0] >> aw) == 16'd0);
  endfunction

  // Decode of the live upstream request.
  always_comb begin
    req_s    = bus.wbs_ufp_cyc_i && bus.wbs_ufp_stb_i;
    hit_s    = win_hit(bus.wbs_ufp_adr_i);
    reject_s = bus.wbs_ufp_we_i && RO_MASK[bus.wbs_ufp_adr_i[19:16]];
    for (int p = 0; p < N_PORTS; p++) begin
      req_oh_s[p] = (bus.wbs_ufp_adr_i[19:16] == 4'(p));
    end
  end

  // Selected-port ack and read data; other ports' acks are masked out.
  always_comb begin
    slv_ack_s = |(bus.wbs_dfp_ack_i & port_sel);
    slv_dat_s = 32'd0;
    for (int p = 0; p < N_PORTS; p++) begin
      slv_dat_s = slv_dat_s | (bus.wbs_dfp_dat_i[32*p +: 32] & {32{port_sel[p]}});
    end
  end

  // Transaction FSM next state; slave ack has priority over timeout and abort.
  always_comb begin
    state_nxt  = state;
    resp_err_s = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_s) begin
          if (hit_s && !reject_s) begin
            state_nxt = ST_WAIT;
          end else begin
            state_nxt  = ST_RESP;
            resp_err_s = 1'b1;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (slv_ack_s) begin
          state_nxt = ST_RESP;
        end else if (wait_cnt == TO_LAST) begin
          state_nxt  = ST_RESP;
          resp_err_s = 1'b1;
        end else if (!bus.wbs_ufp_cyc_i) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, request latch, wait counter, upstream response and error log.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      port_sel <= '0;
      adr_lat  <= 32'd0;
      wait_cnt <= 16'd0;
      ack_reg  <= 1'b0;
      dat_reg  <= 32'd0;
      err_cnt  <= 8'd0;
      err_adr  <= 32'd0;
    end else begin
      state   <= state_nxt;
      ack_reg <= (state_nxt == ST_RESP);
      if ((state == ST_IDLE) && (state_nxt == ST_WAIT)) begin
        port_sel <= req_oh_s;
        adr_lat  <= bus.wbs_ufp_adr_i;
        wait_cnt <= 16'd0;
      end else if ((state == ST_WAIT) && (state_nxt == ST_WAIT)) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (state_nxt == ST_RESP) begin
        dat_reg <= resp_err_s ? DEAD_DATA : slv_dat_s;
      end
      if ((state_nxt == ST_RESP) && resp_err_s) begin
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
        err_adr <= (state == ST_IDLE) ? bus.wbs_ufp_adr_i : adr_lat;
      end
    end
  end

  // Downstream port registers: loaded on entry to WAIT, held through WAIT, zero otherwise.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      dfp_stb <= '0;
      dfp_cyc <= '0;
      dfp_we  <= '0;
      dfp_sel <= '0;
      dfp_dat <= '0;
    end else if (state_nxt == ST_WAIT) begin
      if (state == ST_IDLE) begin
        dfp_stb <= req_oh_s;
        dfp_cyc <= req_oh_s;
        dfp_we  <= req_oh_s & {N_PORTS{bus.wbs_ufp_we_i}};
        for (int p = 0; p < N_PORTS; p++) begin
          dfp_sel[4*p +: 4]   <= req_oh_s[p] ? bus.wbs_ufp_sel_i : 4'd0;
          dfp_dat[32*p +: 32] <= req_oh_s[p] ? bus.wbs_ufp_dat_i : 32'd0;
        end
      end
    end else begin
      dfp_stb <= '0;
      dfp_cyc <= '0;
      dfp_we  <= '0;
      dfp_sel <= '0;
      dfp_dat <= '0;
    end
  end

  assign bus.wbs_ufp_ack_o = ack_reg;
  assign bus.wbs_ufp_dat_o = dat_reg;
  assign bus.wbs_dfp_stb_o = dfp_stb;
  assign bus.wbs_dfp_cyc_o = dfp_cyc;
  assign bus.wbs_dfp_we_o  = dfp_we;
  assign bus.wbs_dfp_sel_o = dfp_sel;
  assign bus.wbs_dfp_dat_o = dfp_dat;
  assign err_count_o       = err_cnt;
  assign last_err_adr_o    = err_adr;

endmodule

// File: tb/tb_wishbone_ram_mux_param.sv
// Scoreboard bench for wishbone_ram_mux_param: a request task predicts each ack
// from the address map rules; an independent monitor pops and compares acks.
module tb_wishbone_ram_mux_param;
  localparam int          NP   = 11;
  localparam int          TO   = 8;
  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic [7:0]  err_count;
  logic [31:0] last_err_adr;

  wishbone_ram_mux_param_if #(.N_PORTS(NP)) bus ();

  wishbone_ram_mux_param #(.N_PORTS(NP), .TIMEOUT(TO)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .bus            (bus),
    .err_count_o    (err_count),
    .last_err_adr_o (last_err_adr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] dat;
    logic [7:0]  cnt;
    logic [31:0] adr;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic        prev_ack = 1'b0;
  int          checks   = 0;
  int          failures = 0;
  int          exp_cnt  = 0;
  logic [31:0] exp_last = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Address map: 0x300 prefix, ports 0..10, 4 KiB windows; port 10 is read-only.
  function automatic bit model_hit(input logic [31:0] adr);
    return (adr[31:20] == 12'h300) && (int'(adr[19:16]) < NP) && (adr[15:0] < 16'd4096);
  endfunction

  function automatic void note_error(input logic [31:0] adr);
    if (exp_cnt < 255) exp_cnt++;
    exp_last = adr;
  endfunction

  task automatic idle_bus();
    bus.wbs_ufp_cyc_i = 1'b0;
    bus.wbs_ufp_stb_i = 1'b0;
    bus.wbs_ufp_we_i  = 1'b0;
    bus.wbs_dfp_ack_i = '0;
  endtask

  task automatic txn(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                     input logic [31:0] wdat, input int delay, input logic [31:0] rdat);
    int idx, exp_lat, exp_stb, lat, stbc;
    bit err_local, tout, done, bad;
    logic [NP-1:0]    e_stb, e_we, ackv;
    logic [4*NP-1:0]  e_sel;
    logic [32*NP-1:0] e_dat;
    exp_t e;
    idx       = int'(adr[19:16]);
    err_local = !model_hit(adr) || (we && idx == 10);
    tout      = !err_local && (delay >= TO);
    if (err_local) begin exp_lat = 1; exp_stb = 0; end
    else if (tout) begin exp_lat = TO + 1; exp_stb = TO; end
    else begin exp_lat = delay + 2; exp_stb = delay + 1; end
    if (err_local || tout) begin
      note_error(adr);
      e.dat = DEAD;
    end else begin
      e.dat = rdat;
    end
    e.cnt = exp_cnt[7:0];
    e.adr = exp_last;
    sbq.push_back(e);
    e_stb = '0; e_we = '0; e_sel = '0; e_dat = '0;
    if (!err_local) begin
      e_stb[idx] = 1'b1;
      e_we[idx]  = we;
      e_sel[4*idx +: 4]  = sel;
      e_dat[32*idx +: 32] = wdat;
    end
    for (int p = 0; p < NP; p++) bus.wbs_dfp_dat_i[32*p +: 32] = $urandom;
    if (idx < NP) bus.wbs_dfp_dat_i[32*idx +: 32] = rdat;
    bus.wbs_ufp_adr_i = adr;
    bus.wbs_ufp_we_i  = we;
    bus.wbs_ufp_sel_i = sel;
    bus.wbs_ufp_dat_i = wdat;
    bus.wbs_ufp_cyc_i = 1'b1;
    bus.wbs_ufp_stb_i = 1'b1;
    @(posedge clk); #1;
    lat = 1; stbc = 0; bad = 1'b0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.wbs_ufp_ack_o === 1'b1) begin
        done = 1'b1;
        if (bus.wbs_dfp_stb_o != '0) bad = 1'b1;
        break;
      end
      if (bus.wbs_dfp_stb_o != '0) begin
        stbc++;
        if (err_local || bus.wbs_dfp_stb_o != e_stb || bus.wbs_dfp_cyc_o != e_stb ||
            bus.wbs_dfp_we_o != e_we || bus.wbs_dfp_sel_o != e_sel || bus.wbs_dfp_dat_o != e_dat)
          bad = 1'b1;
      end else if (bus.wbs_dfp_cyc_o != '0 || bus.wbs_dfp_we_o != '0 ||
                   bus.wbs_dfp_sel_o != '0 || bus.wbs_dfp_dat_o != '0) begin
        bad = 1'b1;
      end
      ackv = NP'($urandom);
      if (idx < NP) begin
        ackv[idx] = 1'b0;
        if (!err_local && bus.wbs_dfp_stb_o[idx] && (stbc - 1 == delay)) ackv[idx] = 1'b1;
      end
      bus.wbs_dfp_ack_i = ackv;
      @(posedge clk); #1;
      lat++;
    end
    idle_bus();
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL txn_no_ack adr=%h waited=%0d cycles", adr, lat);
    end else begin
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("strobe_cycles", 32'(stbc), 32'(exp_stb));
      chk("dfp_pattern", 32'(bad), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic txn_abort(input logic [31:0] adr, input int k);
    int idx;
    idx = int'(adr[19:16]);
    bus.wbs_ufp_adr_i = adr;
    bus.wbs_ufp_we_i  = 1'b0;
    bus.wbs_ufp_sel_i = 4'hF;
    bus.wbs_ufp_cyc_i = 1'b1;
    bus.wbs_ufp_stb_i = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < k; c++) begin @(posedge clk); #1; end
    chk("abort_stb_live", 32'(bus.wbs_dfp_stb_o[idx]), 32'd1);
    idle_bus();
    @(posedge clk); #1;
    chk("abort_stb_drop", 32'(bus.wbs_dfp_stb_o), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_ack", 32'(bus.wbs_ufp_ack_o), 32'd0);
    chk("abort_err_count", {24'd0, err_count}, 32'(exp_cnt));
  endtask

  // Monitor: every upstream ack must match the oldest predicted response.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.wbs_ufp_ack_o === 1'b1) begin
        if (prev_ack) begin
          checks++;
          failures++;
          $display("FAIL ack_pulse_width actual=2+ cycles required=1");
        end
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack dat=%h required=no ack", bus.wbs_ufp_dat_o);
        end else begin
          mon_e = sbq.pop_front();
          chk("ack_dat", bus.wbs_ufp_dat_o, mon_e.dat);
          chk("err_count", {24'd0, err_count}, {24'd0, mon_e.cnt});
          chk("last_err_adr", last_err_adr, mon_e.adr);
        end
      end
      prev_ack = bus.wbs_ufp_ack_o;
    end
  end

  initial begin
    logic [NP-1:0] a;
    logic [11:0]   pre;
    int            ridx, off;
    rst = 1'b1;
    idle_bus();
    bus.wbs_ufp_adr_i = 32'd0;
    bus.wbs_ufp_dat_i = 32'd0;
    bus.wbs_ufp_sel_i = 4'd0;
    bus.wbs_dfp_dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ack", 32'(bus.wbs_ufp_ack_o), 32'd0);
    chk("rst_dat", bus.wbs_ufp_dat_o, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_last_err", last_err_adr, 32'd0);
    chk("rst_dfp_stb", 32'(bus.wbs_dfp_stb_o | bus.wbs_dfp_cyc_o | bus.wbs_dfp_we_o), 32'd0);
    chk("rst_dfp_dat", 32'(|{bus.wbs_dfp_sel_o, bus.wbs_dfp_dat_o}), 32'd0);

    txn(32'h3003_0010, 1'b0, 4'hF, 32'd0, 0, 32'h1234_5678);
    txn(32'h3000_0004, 1'b1, 4'b0011, 32'hA5A5_0001, 0, 32'h0BAD_F00D);

    // Reset while a slave is being strobed; its late ack must be ignored.
    bus.wbs_ufp_adr_i = 32'h3002_0020;
    bus.wbs_ufp_cyc_i = 1'b1;
    bus.wbs_ufp_stb_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_wait_stb_live", 32'(bus.wbs_dfp_stb_o), 32'd4);
    rst = 1'b1;
    idle_bus();
    @(posedge clk); #1;
    chk("rst_wait_stb_drop", 32'(bus.wbs_dfp_stb_o), 32'd0);
    rst = 1'b0;
    a = '0;
    a[2] = 1'b1;
    bus.wbs_dfp_ack_i = a;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.wbs_dfp_ack_i = '0;
    chk("rst_wait_no_ack", 32'(bus.wbs_ufp_ack_o), 32'd0);
    chk("rst_wait_err_count", {24'd0, err_count}, 32'd0);

    txn(32'h300a_0000, 1'b1, 4'hF, 32'h1111_2222, 0, 32'h3333_4444);
    chk("ro_err_count", {24'd0, err_count}, 32'd1);
    chk("ro_last_adr", last_err_adr, 32'h300a_0000);
    txn(32'h300a_0040, 1'b0, 4'hF, 32'd0, 1, 32'h5555_6666);
    txn(32'h3000_1000, 1'b0, 4'hF, 32'd0, 0, 32'h7777_8888);
    txn(32'h300f_0000, 1'b0, 4'hF, 32'd0, 0, 32'h7777_8888);
    txn(32'h3100_0000, 1'b0, 4'hF, 32'd0, 0, 32'h7777_8888);
    chk("unmapped_err_count", {24'd0, err_count}, 32'd4);

    txn(32'h3005_0100, 1'b0, 4'hF, 32'd0, 20, 32'h9999_AAAA);
    txn(32'h3005_0104, 1'b0, 4'hF, 32'd0, TO - 1, 32'hCAFE_0007);
    txn(32'h3006_0000, 1'b1, 4'b1000, 32'h0102_0304, TO, 32'hCAFE_0008);
    txn_abort(32'h3004_0ffc, 3);
    txn(32'h3004_0ff8, 1'b0, 4'hF, 32'd0, 2, 32'h600D_0001);

    for (int i = 0; i < 80; i++) begin
      ridx = $urandom_range(0, 15);
      off  = ($urandom_range(0, 9) == 0) ? $urandom_range(4096, 65535) : $urandom_range(0, 4095);
      pre  = ($urandom_range(0, 9) == 0) ? 12'h301 : 12'h300;
      txn({pre, 4'(ridx), 16'(off)}, 1'($urandom_range(0, 1)), 4'($urandom),
          $urandom, $urandom_range(0, 10), $urandom);
    end

    for (int i = 0; i < 300; i++) begin
      txn({12'h310, 20'($urandom)}, 1'b0, 4'hF, 32'd0, 0, $urandom);
    end
    chk("err_saturate", {24'd0, err_count}, 32'd255);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
